// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
// Used by the FIFO-drain transmitter and its baud tick.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Bit-index width able to hold DATA_W-1 and the stop-bit index.
  function automatic int bit_idx_w(input int data_w);
    if (data_w <= 2) return 1;
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port as seen between the FIFO and the UART drain.
// The UART side (master) issues pops; the FIFO side returns data/flag.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_is_empty;
  logic              fifo_read_en;

  modport master (
    input  fifo_data,
    input  fifo_is_empty,
    output fifo_read_en
  );

  modport slave (
    output fifo_data,
    output fifo_is_empty,
    input  fifo_read_en
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last clk of each bit.
// restart realigns the period so the next bit starts cleanly.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign tick   = w_last;

  // Free-running period counter, cleared on restart or period end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a synchronous FIFO, one pop per frame.
// Frame: start bit, DATA_W bits LSB first, STOP_BITS stop bits.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  uart_tx_fifo_drain_if.master fifo,
  output logic                 tx,
  output logic                 busy
);

  localparam int BIT_W = bit_idx_w(DATA_W);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx_fifo_drain: CLKS_PER_BIT must be >= 2");
  end

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_fifo_drain: STOP_BITS must be 1 or 2");
  end

  if ($clog2(CLKS_PER_BIT + 1) > CNT_W) begin : g_chk_cnt
    $error("uart_tx_fifo_drain: CNT_W too narrow for CLKS_PER_BIT");
  end

  uart_state_e       r_state;
  logic              r_tx;
  logic              r_busy;
  logic              r_read_en;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit_idx;

  logic              w_tick;
  logic              w_restart;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_restart   = (r_state == LOAD);
  assign w_shift_nxt = r_shift >> 1;

  assign tx                = r_tx;
  assign busy              = r_busy;
  assign fifo.fifo_read_en = r_read_en;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_read_en <= 1'b0;
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (enable && !fifo.fifo_is_empty) begin
            r_state   <= POP;
            r_busy    <= 1'b1;
            r_read_en <= 1'b1;
          end
        end
        POP: begin
          r_state   <= LOAD;
          r_read_en <= 1'b0;
        end
        LOAD: begin
          r_shift <= fifo.fifo_data;
          r_tx    <= START_LEVEL;
          r_state <= START;
        end
        START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_tx      <= IDLE_LEVEL;
              r_bit_idx <= '0;
              r_state   <= STOP;
            end else begin
              r_tx      <= w_shift_nxt[0];
              r_shift   <= w_shift_nxt;
              r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_STOP) begin
              r_bit_idx <= '0;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_tx      <= IDLE_LEVEL;
          r_busy    <= 1'b0;
          r_read_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: queue-backed FIFO models feed two
// instances (1 and 2 stop bits); the line is checked every cycle.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic tx1, busy1, tx2, busy2;

  int nchk = 0;
  int nerr = 0;
  int pops1 = 0;
  int last_wait = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_tx_fifo_drain_if #(.DATA_W(8)) f1 ();
  uart_tx_fifo_drain_if #(.DATA_W(8)) f2 ();

  uart_tx_fifo_drain #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .CNT_W(16), .STOP_BITS(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo(f1), .tx(tx1), .busy(busy1)
  );

  uart_tx_fifo_drain #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .CNT_W(16), .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo(f2), .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // FIFO models: registered read data and registered empty flag.
  always @(posedge clk) begin
    if (f1.fifo_read_en && q1.size() > 0) begin
      f1.fifo_data <= q1.pop_front();
      pops1 <= pops1 + 1;
    end
    f1.fifo_is_empty <= (q1.size() == 0);
  end

  always @(posedge clk) begin
    if (f2.fifo_read_en && q2.size() > 0)
      f2.fifo_data <= q2.pop_front();
    f2.fifo_is_empty <= (q2.size() == 0);
  end

  function automatic logic rd(input bit s);
    return s ? f2.fifo_read_en : f1.fifo_read_en;
  endfunction

  function automatic logic txs(input bit s);
    return s ? tx2 : tx1;
  endfunction

  function automatic logic bz(input bit s);
    return s ? busy2 : busy1;
  endfunction

  // Expected line level k cycles after the start-bit fall.
  function automatic logic exp_line(input logic [7:0] w, input int k);
    int ph;
    ph = k / CPB;
    if (ph == 0) return 1'b0;
    if (ph <= 8) return w[ph-1];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a pop, then follow the whole frame cycle by cycle.
  task automatic run_frame(input bit s, input logic [7:0] w,
                           input int drop_at, input int rst_at,
                           input int stop_bits);
    bit got;
    int nlen;
    got = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rd(s)) begin
        got = 1;
        last_wait = t + 1;
        break;
      end
    end
    chk("pop_seen", got, 1);
    if (!got) return;
    chk("pop_busy", bz(s), 1);
    chk("pop_tx", txs(s), 1);
    @(negedge clk);
    chk("load_rd", rd(s), 0);
    chk("load_tx", txs(s), 1);
    chk("load_busy", bz(s), 1);
    nlen = (1 + 8 + stop_bits) * CPB;
    for (int k = 0; k < nlen; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_tx", txs(s), 1);
        chk("rst_busy", bz(s), 0);
        chk("rst_rd", rd(s), 0);
        return;
      end
      chk($sformatf("line_%02h_%0d", w, k), txs(s), exp_line(w, k));
      chk("frame_busy", bz(s), 1);
      chk("frame_rd", rd(s), 0);
      if (k == drop_at) enable = 1'b0;
    end
    @(negedge clk);
    chk("end_busy", bz(s), 0);
    chk("end_tx", txs(s), 1);
    chk("end_rd", rd(s), 0);
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_rd"}, f1.fifo_read_en, 0);
      chk({tag, "_tx"}, tx1, 1);
      chk({tag, "_busy"}, busy1, 0);
    end
  endtask

  initial begin
    int p;
    logic [7:0] rw[6];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_rd1", f1.fifo_read_en, 0);
    chk("rst_tx2", tx2, 1);
    chk("rst_busy2", busy2, 0);
    reset = 1'b0;
    enable = 1'b1;

    // Empty FIFO: nothing happens
    quiet(100, "empty");

    // Single frame 0xA5
    q1.push_back(8'hA5);
    run_frame(0, 8'hA5, -1, -1, 1);

    // Back-to-back 0x00, 0xFF
    p = pops1;
    q1.push_back(8'h00);
    q1.push_back(8'hFF);
    run_frame(0, 8'h00, -1, -1, 1);
    run_frame(0, 8'hFF, -1, -1, 1);
    chk("b2b_next_pop", last_wait, 1);
    quiet(20, "b2b_after");
    chk("b2b_pops", pops1 - p, 2);

    // Enable dropped in bit 3 of 0x3C; 0x55 waits
    p = pops1;
    q1.push_back(8'h3C);
    q1.push_back(8'h55);
    run_frame(0, 8'h3C, 4 * CPB + 1, -1, 1);
    quiet(40, "disabled");
    chk("dis_pops", pops1 - p, 1);
    enable = 1'b1;
    run_frame(0, 8'h55, -1, -1, 1);

    // Reset during bit 5 of 0x81; 0x42 follows
    q1.push_back(8'h81);
    q1.push_back(8'h42);
    run_frame(0, 8'h81, -1, 6 * CPB + 2, 1);
    p = pops1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("inrst_rd", f1.fifo_read_en, 0);
      chk("inrst_tx", tx1, 1);
      chk("inrst_busy", busy1, 0);
    end
    reset = 1'b0;
    run_frame(0, 8'h42, -1, -1, 1);
    chk("rst_pops", pops1 - p, 1);

    // Random words, queued together
    for (int i = 0; i < 6; i++) begin
      rw[i] = 8'($urandom);
      q1.push_back(rw[i]);
    end
    for (int i = 0; i < 6; i++)
      run_frame(0, rw[i], -1, -1, 1);
    quiet(10, "rand_after");

    // Two stop bits: 0x5A and a random word
    q2.push_back(8'h5A);
    run_frame(1, 8'h5A, -1, -1, 2);
    rw[0] = 8'($urandom);
    q2.push_back(rw[0]);
    run_frame(1, rw[0], -1, -1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
